// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_arb_pkg                                                 |
// | Description : Shared types and default parameter values for the FIFO      |
// |               write-port arbiter (state encoding, default sizes, index    |
// |               width helper).                                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package fifo_arb_pkg;

    localparam int c_DEF_NREQ      = 4;
    localparam int c_DEF_WIDTH     = 8;
    localparam int c_DEF_MAX_BURST = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter_if                                           |
// | Description : Bundle between requesters / FIFO and the write arbiter.      |
// |   req      : per-requester beat pending                                    |
// |   req_data : flattened requester data, requester i at [i*WIDTH +: WIDTH]   |
// |   full     : FIFO full flag                                                |
// |   gnt      : one-hot current owner (registered)                            |
// |   ack      : beat accepted this cycle                                      |
// |   wr       : FIFO write enable                                             |
// |   wr_data  : FIFO write data                                               |
// |   busy     : arbiter is inside a burst                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = c_DEF_NREQ,
    parameter int WIDTH = c_DEF_WIDTH
) ();

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic                  full;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic                  wr;
    logic [WIDTH-1:0]      wr_data;
    logic                  busy;

    // Arbiter side.
    modport master (
        input  req, req_data, full,
        output gnt, ack, wr, wr_data, busy
    );

    // Requester / FIFO side.
    modport slave (
        output req, req_data, full,
        input  gnt, ack, wr, wr_data, busy
    );

endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rr_pick                                                      |
// | Description : Combinational round-robin pick. Searches req upward from     |
// |               last_owner+1, wrapping at NREQ-1, and returns the first set  |
// |               bit. last_owner itself is checked last, so a lone previous   |
// |               owner is re-granted.                                         |
// |   req        in  NREQ   request vector                                     |
// |   last_owner in  IDX_W  previous owner                                     |
// |   valid      out 1      any request present                                |
// |   idx        out IDX_W  chosen requester                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = c_DEF_NREQ,
    parameter int IDX_W = idx_width(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] last_owner,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(last_owner) + k) % NREQ);
            if (req[w_cand]) begin
                valid = 1'b1;
                idx   = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fifo_wr_arbiter                                              |
// | Description : Round-robin arbiter sharing one FIFO write port among NREQ   |
// |               requesters, granting bursts of up to MAX_BURST beats and     |
// |               never writing while the FIFO is full.                        |
// |   clk  in  1  write-domain clock                                           |
// |   rst  in  1  asynchronous active-low reset                                |
// |   bus  master modport of fifo_wr_arbiter_if (req/req_data/full in,         |
// |        gnt/ack/wr/wr_data/busy out)                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = c_DEF_NREQ,
    parameter int WIDTH     = c_DEF_WIDTH,
    parameter int MAX_BURST = c_DEF_MAX_BURST
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);

    localparam int c_OW = idx_width(NREQ);
    localparam int c_BW = $clog2(MAX_BURST + 1);

    localparam logic [c_OW-1:0] c_LAST_REQ  = c_OW'(NREQ - 1);
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(MAX_BURST - 1);

    arb_state_t       state_q,      state_d;
    logic [NREQ-1:0]  gnt_q,        gnt_d;
    logic [c_OW-1:0]  owner_q,      owner_d;
    logic [c_OW-1:0]  last_owner_q, last_owner_d;
    logic [c_BW-1:0]  beat_cnt_q,   beat_cnt_d;

    logic             w_pick_valid;
    logic [c_OW-1:0]  w_pick_idx;
    logic             w_owner_req;
    logic             w_wr;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (c_OW)
    ) u_pick (
        .req        (bus.req),
        .last_owner (last_owner_q),
        .valid      (w_pick_valid),
        .idx        (w_pick_idx)
    );

    // Write path is purely combinational so the owner's beat lands in the
    // FIFO at the same edge the requester sees its ack.
    assign w_owner_req = bus.req[owner_q];
    assign w_wr        = (state_q == BURST) && w_owner_req && !bus.full;

    assign bus.wr      = w_wr;
    assign bus.ack     = gnt_q & {NREQ{w_wr}};
    assign bus.gnt     = gnt_q;
    assign bus.busy    = (state_q == BURST);
    assign bus.wr_data = (|gnt_q) ? bus.req_data[owner_q*WIDTH +: WIDTH] : '0;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;

        case (state_q)
            IDLE: begin
                if (w_pick_valid) begin
                    state_d             = BURST;
                    owner_d             = w_pick_idx;
                    gnt_d               = '0;
                    gnt_d[w_pick_idx]   = 1'b1;
                    beat_cnt_d          = '0;
                end
            end

            BURST: begin
                // A dropped request ends the burst even while the FIFO is
                // full; a full FIFO alone only stalls (no timeout).
                if (!w_owner_req || (w_wr && (beat_cnt_q == c_LAST_BEAT))) begin
                    state_d      = IDLE;
                    last_owner_d = owner_q;
                    gnt_d        = '0;
                    beat_cnt_d   = '0;
                end else if (w_wr) begin
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // last_owner resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            owner_q      <= '0;
            last_owner_q <= c_LAST_REQ;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fifo_wr_arbiter                                           |
// | Description : Self-checking bench for fifo_wr_arbiter: directed scenarios  |
// |               plus a randomized run against a behavioural model.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_wr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [WIDTH-1:0] v);
        bus.req_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic settle();
        bus.req  = '0;
        bus.full = 1'b0;
        repeat (3) next_cycle();
    endtask

    task automatic pulse_reset();
        bus.req = '0;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.req      = 4'b1111;
        bus.full     = 1'b0;
        bus.req_data = '0;
        set_slot(0, 8'hA5);
        repeat (2) next_cycle();
        #1;
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", bus.gnt); end
        n_tests++; if (bus.wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b exp=0", bus.wr); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", bus.ack); end
        n_tests++; if (bus.wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data got=%h exp=00", bus.wr_data); end
        rst = 1'b1;
        @(posedge clk);
        #2;
        n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", bus.gnt); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b exp=1", bus.busy); end
        n_tests++; if (bus.wr_data !== 8'hA5) begin n_fail++; $display("FAIL reset_first_data got=%h exp=a5", bus.wr_data); end
        settle();
    endtask

    task automatic test_single();
        logic [3:0] exp_g [8] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
        int cnt = 0;
        for (int c = 0; c < 8; c++) begin
            set_slot(2, 8'(8'h10 + cnt));
            bus.req = (cnt < 6) ? 4'b0100 : 4'b0000;
            #1;
            n_tests++; if (bus.gnt !== exp_g[c]) begin n_fail++; $display("FAIL single_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_g[c]); end
            n_tests++; if (bus.ack !== exp_g[c]) begin n_fail++; $display("FAIL single_ack c=%0d got=%b exp=%b", c, bus.ack, exp_g[c]); end
            if (bus.ack[2]) begin
                n_tests++; if (bus.wr_data !== 8'(8'h10 + cnt)) begin n_fail++; $display("FAIL single_data c=%0d got=%h exp=%h", c, bus.wr_data, 8'(8'h10 + cnt)); end
                cnt++;
            end
            next_cycle();
        end
        n_tests++; if (cnt != 6) begin n_fail++; $display("FAIL single_beats got=%0d exp=6", cnt); end
        settle();
    endtask

    task automatic test_all();
        int cnt [NREQ] = '{0, 0, 0, 0};
        int nw = 0;
        pulse_reset();
        bus.req = 4'b1111;
        for (int c = 0; c < 22; c++) begin
            for (int i = 0; i < NREQ; i++) set_slot(i, {4'(i), 4'(cnt[i])});
            #1;
            if (c % 5 == 1) begin
                n_tests++; if (bus.gnt !== 4'(1 << ((c / 5) % 4))) begin n_fail++; $display("FAIL all_order c=%0d got=%b exp=%b", c, bus.gnt, 4'(1 << ((c / 5) % 4))); end
            end
            if (c % 5 == 0 && c > 0) begin
                n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL all_bubble c=%0d got=%b exp=0000", c, bus.gnt); end
            end
            if (c >= 1 && c <= 20 && bus.wr) nw++;
            for (int i = 0; i < NREQ; i++) begin
                if (bus.ack[i]) begin
                    n_tests++; if (bus.wr_data !== {4'(i), 4'(cnt[i])}) begin n_fail++; $display("FAIL all_data c=%0d got=%h exp=%h", c, bus.wr_data, {4'(i), 4'(cnt[i])}); end
                    cnt[i]++;
                end
            end
            next_cycle();
        end
        n_tests++; if (nw != 16) begin n_fail++; $display("FAIL all_write_count got=%0d exp=16", nw); end
        settle();
    endtask

    task automatic test_full_stall();
        logic       fl    [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0] exp_g [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0};
        logic [3:0] exp_a [9] = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h0};
        int cnt = 0;
        for (int c = 0; c < 9; c++) begin
            set_slot(1, 8'(8'h20 + cnt));
            bus.req  = (cnt < 4) ? 4'b0010 : 4'b0000;
            bus.full = fl[c];
            #1;
            n_tests++; if (bus.gnt !== exp_g[c]) begin n_fail++; $display("FAIL stall_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_g[c]); end
            n_tests++; if (bus.ack !== exp_a[c]) begin n_fail++; $display("FAIL stall_ack c=%0d got=%b exp=%b", c, bus.ack, exp_a[c]); end
            n_tests++; if (bus.wr !== (exp_a[c] != 4'h0)) begin n_fail++; $display("FAIL stall_wr c=%0d got=%b exp=%b", c, bus.wr, exp_a[c] != 4'h0); end
            if (bus.ack[1]) begin
                n_tests++; if (bus.wr_data !== 8'(8'h20 + cnt)) begin n_fail++; $display("FAIL stall_data c=%0d got=%h exp=%h", c, bus.wr_data, 8'(8'h20 + cnt)); end
                cnt++;
            end
            next_cycle();
        end
        settle();
    endtask

    task automatic test_early_drop();
        logic [3:0] exp_g [6] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h8};
        logic [3:0] exp_a [6] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h8};
        int cnt0 = 0;
        set_slot(0, 8'h31);
        set_slot(3, 8'h3C);
        for (int c = 0; c < 6; c++) begin
            bus.req = {(c >= 1), 2'b00, (cnt0 < 2)};
            #1;
            n_tests++; if (bus.gnt !== exp_g[c]) begin n_fail++; $display("FAIL drop_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_g[c]); end
            n_tests++; if (bus.ack !== exp_a[c]) begin n_fail++; $display("FAIL drop_ack c=%0d got=%b exp=%b", c, bus.ack, exp_a[c]); end
            if (c == 5) begin
                n_tests++; if (bus.wr_data !== 8'h3C) begin n_fail++; $display("FAIL drop_data got=%h exp=3c", bus.wr_data); end
            end
            if (bus.ack[0]) cnt0++;
            next_cycle();
        end
        settle();
    endtask

    task automatic test_async_reset();
        set_slot(2, 8'h42);
        bus.req = 4'b0100;
        next_cycle();
        #1;
        n_tests++; if (bus.wr !== 1'b1) begin n_fail++; $display("FAIL areset_pre_wr got=%b exp=1", bus.wr); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL areset_gnt got=%b exp=0000", bus.gnt); end
        n_tests++; if (bus.wr !== 1'b0) begin n_fail++; $display("FAIL areset_wr got=%b exp=0", bus.wr); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy got=%b exp=0", bus.busy); end
        n_tests++; if (bus.ack !== 4'b0000) begin n_fail++; $display("FAIL areset_ack got=%b exp=0000", bus.ack); end
        next_cycle();
        n_tests++; if (bus.wr !== 1'b0) begin n_fail++; $display("FAIL areset_hold_wr got=%b exp=0", bus.wr); end
        bus.req = 4'b1111;
        rst = 1'b1;
        next_cycle();
        n_tests++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL areset_prio got=%b exp=0001", bus.gnt); end
        settle();
    endtask

    task automatic test_random();
        int               m_owner = -1;
        int               m_last  = NREQ - 1;
        int               m_beats = 0;
        logic             pend  [NREQ];
        logic [WIDTH-1:0] pdata [NREQ];
        logic [NREQ-1:0]  reqv;
        logic             fullv;
        logic [NREQ-1:0]  e_g, e_a;
        logic             e_wr, found;
        logic [WIDTH-1:0] e_d;
        pulse_reset();
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b0; pdata[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin pend[i] = 1'b1; pdata[i] = WIDTH'($urandom); end
                else if (pend[i] && $urandom_range(0, 19) == 0) pend[i] = 1'b0;
                reqv[i] = pend[i];
                set_slot(i, pdata[i]);
            end
            fullv    = ($urandom_range(0, 3) == 0);
            bus.req  = reqv;
            bus.full = fullv;
            e_g  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'h0;
            e_wr = (m_owner >= 0) && reqv[m_owner] && !fullv;
            e_a  = e_wr ? e_g : 4'h0;
            e_d  = (m_owner >= 0) ? pdata[m_owner] : '0;
            #1;
            n_tests++; if (bus.gnt !== e_g) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, bus.gnt, e_g); end
            n_tests++; if (bus.wr !== e_wr) begin n_fail++; $display("FAIL rand_wr c=%0d got=%b exp=%b", c, bus.wr, e_wr); end
            n_tests++; if (bus.ack !== e_a) begin n_fail++; $display("FAIL rand_ack c=%0d got=%b exp=%b", c, bus.ack, e_a); end
            n_tests++; if (bus.wr_data !== e_d) begin n_fail++; $display("FAIL rand_data c=%0d got=%h exp=%h", c, bus.wr_data, e_d); end
            n_tests++; if (bus.busy !== (m_owner >= 0)) begin n_fail++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, m_owner >= 0); end
            for (int i = 0; i < NREQ; i++) if (bus.ack[i]) pend[i] = 1'b0;
            // Reference: what the arbiter should own after this edge.
            if (m_owner < 0) begin
                found = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && reqv[(m_last + k) % NREQ]) begin
                        found   = 1'b1;
                        m_owner = (m_last + k) % NREQ;
                        m_beats = 0;
                    end
                end
            end else if (!reqv[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_beats = 0;
            end else if (e_wr) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_beats = 0;
                end
            end
            next_cycle();
        end
        settle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_all();
        test_full_stall();
        test_early_drop();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the write port of one FIFO among NREQ requesters. It sits in the FIFO's write clock domain and drives `wr`/`wr_data` directly. Each grant covers a burst of up to MAX_BURST accepted beats, and it never writes while `full` is high. Each requester uses a zero-latency req/ack handshake: it holds its data while `req` is high and the beat is consumed on `ack`.

## Interface
- `NREQ`, default 4: number of requesters, ≥2.
- `width`, default 8: data width, matching the FIFO.
- `MAX_BURST`, default 4: maximum beats per grant, ≥1.

Ports:
- `clk`  in  1: write-domain clock.
- `rst`  in  1: reset, asynchronous, active-low.
- `req`  in  NREQ: per-requester beat pending. Must stay high with data stable until `ack`.
- `req_data`  in  NREQ*width: flattened data; requester i occupies bits [i*width +: width].
- `full`  in  1: FIFO full flag.
- `gnt`  out  NREQ: one-hot current owner, registered.
- `ack`  out  NREQ: beat accepted this cycle; equals `gnt` & {NREQ{`wr`}}.
- `wr`  out  1: FIFO write enable.
- `wr_data`  out  width: FIFO write data.
- `busy`  out  1: state is BURST.

## Operation
- FSM has two states: IDLE and BURST.
- **IDLE:**
  - If any `req` bit is set, pick the first set bit searching upward and cyclically from `last_owner`+1.
  - Register the pick as `owner`/`gnt`, clear `beat_cnt`, and go to BURST.
  - With no requests, stay in IDLE with `gnt`=0.
- **BURST:**
  - `wr` = `req[owner]` & !`full`. This is combinational, with no registered stage.
  - `wr_data` = `req_data` slice of `owner`; it is 0 whenever `gnt`=0.
  - Each cycle with `wr`=1, `beat_cnt` increments.
- **Exit BURST to IDLE** on either of:
  - `req[owner]`=0 in any cycle, including while `full`=1; or
  - an accepted beat that brings `beat_cnt` to MAX_BURST.
- **On exit:** `last_owner` <= `owner`, `gnt` <= 0, `beat_cnt` <= 0.
- **`full`=1 during BURST:**
  - `wr`=0 and `ack`=0; `beat_cnt` holds; the grant is kept.
  - No timeout applies. A full FIFO stalls the owner indefinitely.
- **Wrap-around:**
  - Owner search wraps from NREQ-1 to 0.
  - If only the previous owner is requesting, it is re-granted.
- **Simultaneous events:** when an exit and a new request land in the same edge, the new request is handled in the following IDLE cycle.
- **Width rules:**
  - `beat_cnt` is $clog2(MAX_BURST+1) bits.
  - `owner` and `last_owner` are $clog2(NREQ) bits (minimum 1).
  - No counter wraps, because exit happens at MAX_BURST.

## Timing
- Reset values:
  - state=IDLE, `gnt`=0, `owner`=0, `last_owner`=NREQ-1 (requester 0 wins first), `beat_cnt`=0.
  - Therefore `wr`=0, `ack`=0, `wr_data`=0, `busy`=0.
- Asserting `rst` mid-burst clears all of the above asynchronously. The beat in flight is not written unless a `clk` edge occurred before reset.
- Latency:
  - `req` high before edge n gives `gnt`/`busy` after edge n.
  - The first `wr`/`ack` happens in cycle n+1 when `full`=0.
- Each IDLE visit costs exactly one bubble cycle. A continuous full-length burst therefore has a period of MAX_BURST+1 cycles.
- `wr`, `ack` and `wr_data` are combinational from registered state, `req`, `req_data` and `full`. The requester and FIFO sample them at the next edge.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state typedef `arb_state_t` {IDLE, BURST};
  - the default-parameter constants.
- Sub-module `rr_pick`: combinational round-robin pick. Inputs `req` and `last_owner`; outputs `valid` and `idx`. It is parameterized by NREQ.
- Top level: FSM, counters and data mux.

## Test plan
Defaults throughout.

1. **Reset:** hold `rst`=0 with `req`=4'b1111 → `gnt`=0, `wr`=0, `busy`=0. Release → `gnt`=4'b0001 after the first edge.
2. **Single requester:** `req[2]` held for 6 beats, `full`=0 → `gnt`=4'b0100. Then 4 consecutive `ack[2]`, 1 idle cycle, re-grant to 2, 2 more acks. `wr_data` matches the driven values 0x10..0x15.
3. **All requesting:** `req`=4'b1111 continuously → grant order 0,1,2,3,0, each with 4 writes, period 5 cycles, 16 writes per 20 cycles.
4. **Full stall:** raise `full` for 3 cycles after beat 2 of owner 1 → `wr`=0 and `ack`=0 for those 3 cycles, `gnt`=4'b0010 held. Beats 3–4 follow, then exit.
5. **Early drop:** owner 0 drops `req` after 2 acks while `req[3]` is pending → IDLE, then `gnt`=4'b1000 (search starts at 1 and skips 1 and 2).
6. **Async reset:** assert `rst` between edges mid-burst → `gnt`, `wr` and `busy` go to 0 immediately with no further write. After release, requester 0 has priority.
